lane_dpram: RTL and testbench

Parametrised true dual-port on-chip buffer for the systolic array's feature-map and weight storage. It is the successor to the plain byte-wide dual-port RAM and adds:
- lane-granular write enables;
- a configurable read pipeline with valid strobes;
- deterministic same-address collision rules;
- a hardware clear engine that zeroes the array after reset or on request.

It sits between the DMA/loader, which writes, and the PE-array feeders, which read.

---
 rtl/systolic_mem_pkg.sv | 18 +
 rtl/lane_dpram_if.sv | 37 +++
 rtl/lane_dpram_rdpipe.sv | 54 +++++
 rtl/lane_dpram.sv | 134 +++++++++++++
 tb/tb_lane_dpram.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_mem_pkg.sv
// rtl/systolic_mem_pkg.sv - shared types and constants for the systolic array buffers
package systolic_mem_pkg;

  // Clear engine states: CLEAR owns the array, IDLE hands it to the ports
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Legal read pipeline depths
  localparam int RD_LAT_1 = 1;
  localparam int RD_LAT_2 = 2;

  // One 416x416x3 frame
  localparam int DEFAULT_ADDR_WIDTH = 19;
  localparam int DEFAULT_DEPTH      = 416 * 416 * 3;

endpackage

// File: rtl/lane_dpram_if.sv
// rtl/lane_dpram_if.sv - dual-port request/response bundle for lane_dpram
interface lane_dpram_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int LANES      = 4,
  parameter int LANE_WIDTH = 8
);
  localparam int W = LANES * LANE_WIDTH;

  logic                  en_a;
  logic                  we_a;
  logic [LANES-1:0]      be_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [W-1:0]          din_a;
  logic [W-1:0]          dout_a;
  logic                  vld_a;

  logic                  en_b;
  logic                  we_b;
  logic [LANES-1:0]      be_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [W-1:0]          din_b;
  logic [W-1:0]          dout_b;
  logic                  vld_b;

  modport master (
    output en_a, we_a, be_a, addr_a, din_a,
    output en_b, we_b, be_b, addr_b, din_b,
    input  dout_a, vld_a, dout_b, vld_b
  );

  modport slave (
    input  en_a, we_a, be_a, addr_a, din_a,
    input  en_b, we_b, be_b, addr_b, din_b,
    output dout_a, vld_a, dout_b, vld_b
  );

endinterface

// File: rtl/lane_dpram_rdpipe.sv
// rtl/lane_dpram_rdpipe.sv - 1- or 2-stage read data/valid pipeline for one port
module lane_dpram_rdpipe
  import systolic_mem_pkg::*;
#(
  parameter int W          = 32,
  parameter int RD_LATENCY = RD_LAT_1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rd_req,
  input  logic [W-1:0] rd_data,
  output logic [W-1:0] dout,
  output logic         vld
);

  logic [W-1:0] s1_data;
  logic         s1_vld;

  // Stage 1 only loads on an accepted read so dout holds between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data <= '0;
      s1_vld  <= 1'b0;
    end else begin
      s1_vld <= rd_req;
      if (rd_req) s1_data <= rd_data;
    end
  end

  generate
    if (RD_LATENCY == RD_LAT_2) begin : g_two
      logic [W-1:0] s2_data;
      logic         s2_vld;

      // Optional output register, again loaded only when stage 1 is valid
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_data <= '0;
          s2_vld  <= 1'b0;
        end else begin
          s2_vld <= s1_vld;
          if (s1_vld) s2_data <= s1_data;
        end
      end

      assign dout = s2_data;
      assign vld  = s2_vld;
    end else begin : g_one
      assign dout = s1_data;
      assign vld  = s1_vld;
    end
  endgenerate

endmodule

// File: rtl/lane_dpram.sv
// rtl/lane_dpram.sv - lane-enabled true dual-port buffer with clear engine; optional LANE_DPRAM_COLLISION_EN
module lane_dpram
  import systolic_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int LANE_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int RD_LATENCY = RD_LAT_1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic busy,
`ifdef LANE_DPRAM_COLLISION_EN
  output logic collision,
`endif
  lane_dpram_if.slave bus
);

  localparam int W     = LANES * LANE_WIDTH;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  clear_start;

  logic [W-1:0] mem [DEPTH];

  logic         acc_a, acc_b, in_a, in_b, rd_a, rd_b, wr_a, wr_b;
  logic [W-1:0] raw_a, raw_b;

  // Clear engine state register; reset lands in CLEAR so the array is zeroed after power-up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Clear engine next state: walk 0..DEPTH-1 once, ignore further clear pulses meanwhile
  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clear_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d     = CLEAR;
          clr_addr_d  = '0;
          clear_start = 1'b1;
        end
      end
      CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = IDLE;
          clr_addr_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q == CLEAR);
  assign acc_a = bus.en_a & ~busy;
  assign acc_b = bus.en_b & ~busy;
  assign in_a  = (bus.addr_a <= LAST_ADDR);
  assign in_b  = (bus.addr_b <= LAST_ADDR);
  assign rd_a  = acc_a & ~bus.we_a;
  assign rd_b  = acc_b & ~bus.we_b;
  assign wr_a  = acc_a & bus.we_a & in_a;
  assign wr_b  = acc_b & bus.we_b & in_b;

  // Asynchronous array read sampled by the pipeline at the same edge as writes: read-first
  always_comb begin
    raw_a = '0;
    raw_b = '0;
    if (in_a) raw_a = mem[bus.addr_a[IDX_W-1:0]];
    if (in_b) raw_b = mem[bus.addr_b[IDX_W-1:0]];
  end

  // Array write: clear owns every cycle in CLEAR; port A is applied last so it wins shared lanes
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_addr_q[IDX_W-1:0]] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_b && bus.be_b[i])
          mem[bus.addr_b[IDX_W-1:0]][i*LANE_WIDTH +: LANE_WIDTH] <= bus.din_b[i*LANE_WIDTH +: LANE_WIDTH];
      end
      for (int i = 0; i < LANES; i++) begin
        if (wr_a && bus.be_a[i])
          mem[bus.addr_a[IDX_W-1:0]][i*LANE_WIDTH +: LANE_WIDTH] <= bus.din_a[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

`ifdef LANE_DPRAM_COLLISION_EN
  logic coll_evt;

  assign coll_evt = acc_a & acc_b & in_a & in_b & (bus.addr_a == bus.addr_b) & (bus.we_a | bus.we_b);

  // Sticky collision flag; starting a clear wipes the history along with the data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           collision <= 1'b0;
    else if (clear_start) collision <= 1'b0;
    else if (coll_evt)    collision <= 1'b1;
  end
`endif

  lane_dpram_rdpipe #(.W(W), .RD_LATENCY(RD_LATENCY)) u_rdpipe_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_req  (rd_a),
    .rd_data (raw_a),
    .dout    (bus.dout_a),
    .vld     (bus.vld_a)
  );

  lane_dpram_rdpipe #(.W(W), .RD_LATENCY(RD_LATENCY)) u_rdpipe_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_req  (rd_b),
    .rd_data (raw_b),
    .dout    (bus.dout_b),
    .vld     (bus.vld_b)
  );

endmodule

// File: tb/tb_lane_dpram.sv
// tb/tb_lane_dpram.sv - self-checking bench for lane_dpram with a behavioural reference model
module tb_lane_dpram;
  import systolic_mem_pkg::*;

  localparam int AW    = 5;
  localparam int DEPTH = 16;
  localparam int LW    = 8;
  localparam int LN    = 4;
  localparam int RDL   = RD_LAT_1;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  logic busy;
`ifdef LANE_DPRAM_COLLISION_EN
  logic collision;
`endif

  lane_dpram_if #(.ADDR_WIDTH(AW), .LANES(LN), .LANE_WIDTH(LW)) bus ();

  lane_dpram #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .LANE_WIDTH (LW),
    .LANES      (LN),
    .RD_LATENCY (RDL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .busy      (busy),
`ifdef LANE_DPRAM_COLLISION_EN
    .collision (collision),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  typedef struct {
    logic        en_a, we_a;
    logic [3:0]  be_a;
    logic [4:0]  addr_a;
    logic [31:0] din_a;
    logic        en_b, we_b;
    logic [3:0]  be_b;
    logic [4:0]  addr_b;
    logic [31:0] din_b;
    logic        chk_a;
    logic [31:0] exp_a;
    logic        chk_b;
    logic [31:0] exp_b;
  } vec_t;

  logic [31:0] m_mem [DEPTH];
  rd_t         qa[$], qb[$];
  int          clr_left;
  int          cyc;
  logic [31:0] exp_dout_a, exp_dout_b;
  logic        exp_coll;
  logic [31:0] cap_a, cap_b;
  int          n_cmp, n_bad;
  vec_t        vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic drive(input logic ea, input logic wa, input logic [3:0] ba, input logic [4:0] aa, input logic [31:0] da,
                       input logic eb, input logic wb, input logic [3:0] bb, input logic [4:0] ab, input logic [31:0] db);
    bus.en_a = ea; bus.we_a = wa; bus.be_a = ba; bus.addr_a = aa; bus.din_a = da;
    bus.en_b = eb; bus.we_b = wb; bus.be_b = bb; bus.addr_b = ab; bus.din_b = db;
  endtask

  task automatic idle();
    drive(0, 0, 4'h0, 5'd0, 32'h0, 0, 0, 4'h0, 5'd0, 32'h0);
  endtask

  // One clock: update the model from the inputs seen at the edge, then compare all outputs
  task automatic tick();
    logic acc_a, acc_b, ex_va, ex_vb;
    @(posedge clk);
    if (!rst_n) begin
      qa.delete(); qb.delete();
      exp_dout_a = '0; exp_dout_b = '0; exp_coll = 1'b0;
      clr_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else begin
      acc_a = bus.en_a && (clr_left == 0);
      acc_b = bus.en_b && (clr_left == 0);
      if (acc_a && !bus.we_a) qa.push_back('{cyc + RDL, (bus.addr_a < DEPTH) ? m_mem[bus.addr_a] : 32'h0});
      if (acc_b && !bus.we_b) qb.push_back('{cyc + RDL, (bus.addr_b < DEPTH) ? m_mem[bus.addr_b] : 32'h0});
      if (acc_a && acc_b && bus.addr_a == bus.addr_b && bus.addr_a < DEPTH && (bus.we_a || bus.we_b))
        exp_coll = 1'b1;
      if (acc_b && bus.we_b && bus.addr_b < DEPTH) m_mem[bus.addr_b] = merge(m_mem[bus.addr_b], bus.din_b, bus.be_b);
      if (acc_a && bus.we_a && bus.addr_a < DEPTH) m_mem[bus.addr_a] = merge(m_mem[bus.addr_a], bus.din_a, bus.be_a);
      if (clr_left > 0) clr_left--;
      else if (clear) begin
        clr_left = DEPTH;
        exp_coll = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end
    end
    cyc++;
    #1;
    ex_va = (qa.size() > 0) && (qa[0].due == cyc);
    ex_vb = (qb.size() > 0) && (qb[0].due == cyc);
    if (ex_va) begin exp_dout_a = qa[0].data; void'(qa.pop_front()); end
    if (ex_vb) begin exp_dout_b = qb[0].data; void'(qb.pop_front()); end
    chk("vld_a", 64'(bus.vld_a), 64'(ex_va));
    chk("vld_b", 64'(bus.vld_b), 64'(ex_vb));
    chk("dout_a", 64'(bus.dout_a), 64'(exp_dout_a));
    chk("dout_b", 64'(bus.dout_b), 64'(exp_dout_b));
    chk("busy", 64'(busy), 64'(clr_left > 0));
`ifdef LANE_DPRAM_COLLISION_EN
    chk("collision", 64'(collision), 64'(exp_coll));
`endif
    if (bus.vld_a) cap_a = bus.dout_a;
    if (bus.vld_b) cap_b = bus.dout_b;
  endtask

  task automatic busy_run();
    int n;
    n = 0;
    for (int k = 0; k < 40 && busy; k++) begin
      n++;
      tick();
    end
    chk("busy_cycles", 64'(n), 64'(DEPTH));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    rst_n = 1'b0; clear = 1'b0;
    idle();
    vecs[0]  = '{1,1,4'b0101,5'd3,32'hAABBCCDD, 0,0,4'h0,5'd0,32'h0,        0,32'h0,        0,32'h0};
    vecs[1]  = '{1,0,4'h0,5'd3,32'h0,           0,0,4'h0,5'd0,32'h0,        1,32'h00BB00DD, 0,32'h0};
    vecs[2]  = '{1,1,4'hF,5'd5,32'h11111111,    1,1,4'hC,5'd5,32'h22222222, 0,32'h0,        0,32'h0};
    vecs[3]  = '{1,0,4'h0,5'd5,32'h0,           1,0,4'h0,5'd5,32'h0,        1,32'h11111111, 1,32'h11111111};
    vecs[4]  = '{1,1,4'hF,5'd7,32'h12345678,    0,0,4'h0,5'd0,32'h0,        0,32'h0,        0,32'h0};
    vecs[5]  = '{1,1,4'hF,5'd7,32'hFFFFFFFF,    1,0,4'h0,5'd7,32'h0,        0,32'h0,        1,32'h12345678};
    vecs[6]  = '{1,0,4'h0,5'd7,32'h0,           1,0,4'h0,5'd3,32'h0,        1,32'hFFFFFFFF, 1,32'h00BB00DD};
    vecs[7]  = '{1,0,4'h0,5'd20,32'h0,          0,0,4'h0,5'd0,32'h0,        1,32'h0,        0,32'h0};
    vecs[8]  = '{1,1,4'h0,5'd3,32'hFFFFFFFF,    1,1,4'hF,5'd20,32'hDEADBEEF,0,32'h0,        0,32'h0};
    vecs[9]  = '{1,0,4'h0,5'd3,32'h0,           1,0,4'h0,5'd4,32'h0,        1,32'h00BB00DD, 1,32'h0};
    vecs[10] = '{1,1,4'h3,5'd9,32'h0000BEEF,    1,1,4'hC,5'd9,32'hCAFE0000, 0,32'h0,        0,32'h0};
    vecs[11] = '{1,0,4'h0,5'd9,32'h0,           1,0,4'h0,5'd20,32'h0,       1,32'hCAFEBEEF, 1,32'h0};

    tick(); tick();
    rst_n = 1'b1;
    busy_run();

    for (int a = 0; a < DEPTH; a++) begin
      drive(1, 0, 4'h0, 5'(a), 32'h0, 1, 0, 4'h0, 5'(DEPTH - 1 - a), 32'h0);
      cap_a = 'x;
      tick();
      chk("init_zero", 64'(cap_a), 64'h0);
    end
    idle();
    repeat (RDL) tick();

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].en_a, vecs[i].we_a, vecs[i].be_a, vecs[i].addr_a, vecs[i].din_a,
            vecs[i].en_b, vecs[i].we_b, vecs[i].be_b, vecs[i].addr_b, vecs[i].din_b);
      cap_a = 'x; cap_b = 'x;
      tick();
      idle();
      repeat (RDL - 1) tick();
      if (vecs[i].chk_a) chk($sformatf("vec%0d_a", i), 64'(cap_a), 64'(vecs[i].exp_a));
      if (vecs[i].chk_b) chk($sformatf("vec%0d_b", i), 64'(cap_b), 64'(vecs[i].exp_b));
    end

    for (int a = 0; a < DEPTH; a++) begin
      drive(1, 0, 4'h0, 5'(a), 32'h0, 1, 0, 4'h0, 5'(a), 32'h0);
      tick();
    end
    idle();
    repeat (RDL) tick();

    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom), 5'($urandom_range(0, 19)), $urandom,
            $urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom), 5'($urandom_range(0, 19)), $urandom);
      clear = ($urandom_range(0, 63) == 0);
      tick();
      clear = 1'b0;
    end
    idle();
    for (int k = 0; k < 40 && busy; k++) tick();

    for (int a = 0; a < DEPTH; a++) begin
      drive(1, 1, 4'hF, 5'(a), $urandom | 32'h1, 0, 0, 4'h0, 5'd0, 32'h0);
      tick();
    end
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 0; k < 7; k++) begin
      drive(1, 0, 4'h0, 5'(k), 32'h0, 1, 1, 4'hF, 5'(k), 32'hFFFFFFFF);
      tick();
    end
    idle();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    busy_run();
    for (int a = 0; a < DEPTH; a++) begin
      drive(1, 0, 4'h0, 5'(a), 32'h0, 0, 0, 4'h0, 5'd0, 32'h0);
      cap_a = 'x;
      tick();
      chk("post_rst_zero", 64'(cap_a), 64'h0);
    end
    idle();
    repeat (RDL + 1) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
